// File: rtl/ref_level_ctrl_pkg.sv
// rtl/ref_level_ctrl_pkg.sv - shared state encodings, scale constant and product truncation
package ref_level_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL1 = 2'd1,
        S_MUL2 = 2'd2
    } seq_state_t;

    localparam logic signed [17:0] DEFAULT_POWER_SCALE = 18'sd65536;

    // 1.17 x 1.17 gives a 2.34 product; keep bits [34:17] to return to 1.17
    function automatic logic [17:0] trunc_36_18(input logic signed [35:0] prod);
        return prod[34:17];
    endfunction

endpackage

// File: rtl/ref_power_seq.sv
// rtl/ref_power_seq.sv - two-step shared-multiplier power sequencer
module ref_power_seq
    import ref_level_ctrl_pkg::*;
#(
    parameter logic signed [17:0] POWER_SCALE = DEFAULT_POWER_SCALE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [17:0] ref_level,
    output logic [17:0] avg_power,
    output logic        power_valid
);

    seq_state_t seq_q, seq_d;
    logic signed [17:0] inter_q;
    logic signed [17:0] mul_a, mul_b;
    logic signed [35:0] prod;

    // go arrives with the window update edge, so MUL1 sees the new ref_level
    always_comb begin
        seq_d = seq_q;
        mul_a = $signed(ref_level);
        mul_b = $signed(ref_level);
        case (seq_q)
            S_IDLE: if (go) seq_d = S_MUL1;
            S_MUL1: seq_d = S_MUL2;
            S_MUL2: begin
                mul_a = inter_q;
                mul_b = POWER_SCALE;
                seq_d = S_IDLE;
            end
            default: seq_d = S_IDLE;
        endcase
    end

    assign prod = mul_a * mul_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q       <= S_IDLE;
            inter_q     <= '0;
            avg_power   <= '0;
            power_valid <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            power_valid <= 1'b0;
            if (seq_q == S_MUL1) begin
                inter_q <= $signed(trunc_36_18(prod));
            end
            if (seq_q == S_MUL2) begin
                avg_power   <= trunc_36_18(prod);
                power_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ref_level_ctrl.sv
// rtl/ref_level_ctrl.sv - windowed reference-level accumulator and acquisition/track/hold FSM
module ref_level_ctrl
    import ref_level_ctrl_pkg::*;
#(
    parameter int                 WIN_LOG2    = 10,
    parameter int                 ACQ_WINDOWS = 2,
    parameter logic signed [17:0] POWER_SCALE = DEFAULT_POWER_SCALE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic        freeze,
    input  logic [17:0] dec_var,
    output logic [17:0] ref_level,
    output logic [17:0] avg_power,
    output logic        ref_valid,
    output logic        power_valid,
    output logic        window_done,
    output logic [1:0]  state
);

    localparam int ACC_W = 18 + WIN_LOG2;

    ctrl_state_t         state_q, state_d, origin_q;
    logic [17:0]         mag_q, mag_d;
    logic [ACC_W-1:0]    acc_q, acc_sum;
    logic [WIN_LOG2-1:0] sym_cnt_q;
    logic [3:0]          win_cnt_q;
    logic                accum_en, boundary, acq_done;

    // most negative input has no positive twin in 1.17, so it saturates
    always_comb begin
        if (dec_var == 18'h20000)
            mag_d = 18'h1FFFF;
        else if (dec_var[17])
            mag_d = ~dec_var + 18'd1;
        else
            mag_d = dec_var;
    end

    assign acc_sum  = acc_q + ACC_W'(mag_q);
    assign accum_en = clk_en && !start && !freeze
                      && (state_q == ST_ACQ || state_q == ST_TRACK);
    assign boundary = accum_en && (sym_cnt_q == {WIN_LOG2{1'b1}});
    assign acq_done = boundary && (state_q == ST_ACQ)
                      && (win_cnt_q == 4'(ACQ_WINDOWS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ACQ;
            ST_ACQ: begin
                if (start)         state_d = ST_ACQ;
                else if (freeze)   state_d = ST_HOLD;
                else if (acq_done) state_d = ST_TRACK;
            end
            ST_TRACK: begin
                if (start)       state_d = ST_ACQ;
                else if (freeze) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (start)        state_d = ST_ACQ;
                else if (!freeze) state_d = origin_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            origin_q    <= ST_IDLE;
            mag_q       <= '0;
            acc_q       <= '0;
            sym_cnt_q   <= '0;
            win_cnt_q   <= '0;
            ref_level   <= '0;
            ref_valid   <= 1'b0;
            window_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            window_done <= 1'b0;
            if (clk_en) mag_q <= mag_d;
            if (state_q != ST_HOLD && state_d == ST_HOLD) origin_q <= state_q;
            if (start) begin
                acc_q     <= '0;
                sym_cnt_q <= '0;
                win_cnt_q <= '0;
                ref_valid <= 1'b0;
            end else if (accum_en) begin
                sym_cnt_q <= sym_cnt_q + WIN_LOG2'(1);
                if (boundary) begin
                    acc_q       <= '0;
                    ref_level   <= acc_sum[WIN_LOG2 +: 18];
                    window_done <= 1'b1;
                    if (state_q == ST_ACQ) win_cnt_q <= win_cnt_q + 4'd1;
                    if (acq_done) ref_valid <= 1'b1;
                end else begin
                    acc_q <= acc_sum;
                end
            end
        end
    end

    assign state = state_q;

    ref_power_seq #(
        .POWER_SCALE(POWER_SCALE)
    ) u_power_seq (
        .clk        (clk),
        .reset      (reset),
        .go         (boundary),
        .ref_level  (ref_level),
        .avg_power  (avg_power),
        .power_valid(power_valid)
    );

endmodule

// File: tb/tb_ref_level_ctrl.sv
// tb/tb_ref_level_ctrl.sv - directed self-checking bench for ref_level_ctrl
module tb_ref_level_ctrl;

    logic        clk = 1'b0;
    logic        reset, clk_en, start, freeze;
    logic [17:0] dec_var;
    logic [17:0] ref_level, avg_power;
    logic        ref_valid, power_valid, window_done;
    logic [1:0]  state;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   wd_cnt = 0;
    int   pv_cnt = 0;
    int   wd_cyc = 0;
    int   pv_cyc = 0;
    int   wd_base, pv_base;
    logic rv_at_wd = 1'b0;

    ref_level_ctrl #(
        .WIN_LOG2   (2),
        .ACQ_WINDOWS(2),
        .POWER_SCALE(18'sd65536)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .start      (start),
        .freeze     (freeze),
        .dec_var    (dec_var),
        .ref_level  (ref_level),
        .avg_power  (avg_power),
        .ref_valid  (ref_valid),
        .power_valid(power_valid),
        .window_done(window_done),
        .state      (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (window_done === 1'b1) begin
            wd_cnt   <= wd_cnt + 1;
            wd_cyc   <= cyc;
            rv_at_wd <= ref_valid;
        end
        if (power_valid === 1'b1) begin
            pv_cnt <= pv_cnt + 1;
            pv_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one symbol: clk_en for one clk, then three idle clks
    task automatic sym(input logic [17:0] v);
        dec_var = v;
        clk_en  = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        clk_en  = 1'b0;
        start   = 1'b0;
        freeze  = 1'b0;
        dec_var = '0;
        repeat (2) @(negedge clk);
        check("rst_state", state, 0);
        check("rst_ref_level", ref_level, 0);
        check("rst_avg_power", avg_power, 0);
        check("rst_ref_valid", ref_valid, 0);
        check("rst_window_done", window_done, 0);
        check("rst_power_valid", power_valid, 0);
        reset = 1'b0;
        @(negedge clk);

        // scenario 1: constant 40000
        sym(18'd40000);
        check("idle_no_accum_state", state, 0);
        check("idle_no_window", wd_cnt, 0);
        pulse_start();
        check("s1_state_acq", state, 1);
        repeat (4) sym(18'd40000);
        check("s1_w1_ref_level", ref_level, 40000);
        check("s1_w1_wd_cnt", wd_cnt, 1);
        check("s1_w1_rv_at_wd", rv_at_wd, 0);
        check("s1_w1_ref_valid", ref_valid, 0);
        check("s1_w1_state", state, 1);
        check("s1_w1_avg_power", avg_power, 6103);
        check("s1_w1_pv_cnt", pv_cnt, 1);
        check("s1_pv_latency", pv_cyc - wd_cyc, 2);
        repeat (4) sym(18'd40000);
        check("s1_w2_rv_at_wd", rv_at_wd, 1);
        check("s1_w2_ref_valid", ref_valid, 1);
        check("s1_w2_state", state, 2);
        check("s1_w2_wd_cnt", wd_cnt, 2);
        check("s1_w2_ref_level", ref_level, 40000);
        check("s1_w2_avg_power", avg_power, 6103);
        check("s1_w2_pv_cnt", pv_cnt, 2);

        // scenario 2: negative inputs and saturation
        repeat (4) sym(-18'sd40000);
        check("s2_neg_ref_level", ref_level, 40000);
        check("s2_neg_avg_power", avg_power, 6103);
        repeat (4) sym(18'h20000);
        check("s2_pipeline_ref_level", ref_level, 108303);
        repeat (4) sym(18'h20000);
        check("s2_sat_ref_level", ref_level, 131071);
        check("s2_sat_avg_power", avg_power, 65535);

        // scenario 3: restart, then alternating 10000/30000
        sym(18'd10000);
        pulse_start();
        check("s3_restart_state", state, 1);
        check("s3_restart_ref_valid", ref_valid, 0);
        check("s3_restart_ref_level", ref_level, 131071);
        check("s3_restart_avg_power", avg_power, 65535);
        repeat (2) begin
            sym(18'd30000);
            sym(18'd10000);
        end
        check("s3_w1_ref_level", ref_level, 20000);
        check("s3_w1_avg_power", avg_power, 1525);
        check("s3_w1_state", state, 1);
        repeat (2) begin
            sym(18'd30000);
            sym(18'd10000);
        end
        check("s3_w2_state", state, 2);
        check("s3_w2_ref_valid", ref_valid, 1);

        // scenario 4: freeze mid-window in TRACK
        wd_base = wd_cnt;
        sym(18'd40000);
        sym(18'd40000);
        freeze = 1'b1;
        @(negedge clk);
        repeat (10) sym(18'd40000);
        check("s4_hold_state", state, 3);
        check("s4_hold_ref_valid", ref_valid, 1);
        check("s4_hold_ref_level", ref_level, 20000);
        check("s4_hold_avg_power", avg_power, 1525);
        check("s4_hold_no_window", wd_cnt, wd_base);
        freeze = 1'b0;
        @(negedge clk);
        check("s4_release_state", state, 2);
        sym(18'd40000);
        check("s4_three_samples_no_window", wd_cnt, wd_base);
        sym(18'd40000);
        check("s4_fourth_sample_window", wd_cnt, wd_base + 1);
        check("s4_ref_level", ref_level, 32500);
        check("s4_avg_power", avg_power, 4029);

        // scenario 5: start and freeze together in TRACK
        sym(18'd40000);
        start  = 1'b1;
        freeze = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        freeze = 1'b0;
        @(negedge clk);
        check("s5_state", state, 1);
        check("s5_ref_valid", ref_valid, 0);
        check("s5_ref_level", ref_level, 32500);
        repeat (7) sym(18'd40000);
        check("s5_seven_ref_valid", ref_valid, 0);
        check("s5_seven_state", state, 1);
        sym(18'd40000);
        check("s5_eight_ref_valid", ref_valid, 1);
        check("s5_eight_state", state, 2);
        check("s5_eight_ref_level", ref_level, 40000);

        // scenario 6: reset between window_done and power_valid
        repeat (3) sym(18'd40000);
        dec_var = 18'd40000;
        clk_en  = 1'b1;
        @(negedge clk);
        clk_en = 1'b0;
        check("s6_window_done", window_done, 1);
        pv_base = pv_cnt;
        reset = 1'b1;
        #1;
        check("s6_rst_state", state, 0);
        check("s6_rst_ref_level", ref_level, 0);
        check("s6_rst_avg_power", avg_power, 0);
        check("s6_rst_ref_valid", ref_valid, 0);
        check("s6_rst_window_done", window_done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("s6_no_power_valid", pv_cnt, pv_base);
        check("s6_post_avg_power", avg_power, 0);
        check("s6_post_state", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ref_level_ctrl.md
Name: ref_level_ctrl

Overview:
Windowed controller for symbol-slicer reference-level and average-power estimation in the MOD465 receiver.
- Accumulates the decision-variable magnitude over fixed windows of 2^WIN_LOG2 symbols, one symbol per clk_en.
- At each window boundary it publishes the window-average reference level.
- It then sequences one shared 18x18 multiplier through the power computation: ref_level², then × POWER_SCALE.
- Provides acquisition/track/hold sequencing with valid flags so the slicer knows when the reference can be trusted.

Parameters:
- WIN_LOG2, 10: log2 of window length in symbols (window = 2^WIN_LOG2).
- ACQ_WINDOWS, 2: number of complete windows in ACQ before ref_valid asserts; range 1..15.
- POWER_SCALE, 18'sd65536: signed 1.17 scale for the power estimate (65536 = 0.5).

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- clk_en  in  1  symbol strobe; one dec_var sample per asserted cycle
- start  in  1  single-cycle pulse; begins or restarts acquisition
- freeze  in  1  level; pauses accumulation and holds outputs
- dec_var  in  18  signed 1.17 decision variable
- ref_level  out  18  signed window-average magnitude, never negative
- avg_power  out  18  signed scaled power estimate
- ref_valid  out  1  ref_level trusted; high only in TRACK, and in HOLD entered from TRACK
- power_valid  out  1  one-clk pulse when avg_power updates
- window_done  out  1  one-clk pulse when ref_level updates
- state  out  2  IDLE=0, ACQ=1, TRACK=2, HOLD=3

Behaviour:
- Reset: async, active-high; clock clk. Clears all registers: outputs 0, state IDLE, accumulator 0, counters 0, sequencer idle.
- Magnitude: mag = |dec_var|; dec_var = -131072 saturates to 131071. Registered on clk_en, giving one symbol of pipeline latency.
- Accumulator: 18+WIN_LOG2 bits, unsigned, cannot overflow. Adds mag on each clk_en while in ACQ or TRACK.
- Symbol counter: WIN_LOG2 bits, counts accumulated samples. On the clk_en that adds the 2^WIN_LOG2-th sample:
  - ref_level <= (acc + mag) >> WIN_LOG2, low 18 bits;
  - acc <= 0;
  - counter wraps to 0;
  - window_done pulses on the following clk.
- Power sequencer, free-running on clk and independent of clk_en:
  - S_MUL1, the cycle after the window update: inter <= (ref_level*ref_level)[34:17].
  - S_MUL2: avg_power <= (inter*POWER_SCALE)[34:17]; power_valid pulses that cycle.
  - avg_power is therefore valid 2 clks after window_done.
  - A single shared multiplier is muxed by sequencer state.
- State transitions:
  - IDLE: no accumulation; start -> ACQ.
  - ACQ: window counter increments per completed window. At ACQ_WINDOWS -> TRACK, and ref_valid rises in the same cycle as that window's window_done.
  - TRACK: updates every window.
  - Any of ACQ/TRACK with freeze -> HOLD. HOLD records its origin state and returns there when freeze deasserts.
  - HOLD: accumulator, symbol counter and window counter are paused, not cleared. Outputs are held; ref_valid keeps its pre-HOLD value.
- start in ACQ/TRACK/HOLD: clear acc, symbol counter, window counter and ref_valid, then go to ACQ. ref_level and avg_power keep their last values.
- Simultaneous events:
  - start beats freeze.
  - freeze beats a clk_en window boundary; that sample is dropped.
  - A power sequence already in flight always completes, even across freeze or start.
- reset mid-window or mid-sequence: immediate return to the reset state; partial window discarded.

Decomposition:
- Shared defines header:
  - state encodings;
  - the 36-to-18 truncation function, bits [34:17];
  - the default POWER_SCALE constant.
- One sub-module, ref_power_seq: the two-step shared-multiplier power sequencer. Inputs are a start pulse and ref_level; outputs are avg_power and power_valid.
- Accumulator and FSM stay in ref_level_ctrl.

Test Plan:
All scenarios use WIN_LOG2=2, ACQ_WINDOWS=2, POWER_SCALE=65536, with clk_en every 4th clk.
1. Constant dec_var=40000, start pulse:
   - ref_level=40000 after each window;
   - ref_valid rises on the 2nd window_done (8 samples);
   - avg_power=6103 two clks after each window_done; power_valid pulses.
2. dec_var=-40000 -> identical results to scenario 1. dec_var=-131072 -> ref_level=131071, avg_power=65535.
3. Alternating 10000/30000 -> ref_level=20000 every window; state goes 1 -> 2 after two windows.
4. In TRACK, assert freeze for 10 symbols mid-window:
   - state=3, ref_level and avg_power unchanged, ref_valid stays 1;
   - after release, the window completes after exactly 4 accumulated samples in total.
5. In TRACK, pulse start in the same cycle as freeze:
   - state=1, ref_valid=0, ref_level held;
   - 8 further symbols are needed before ref_valid=1.
6. Assert reset between window_done and power_valid: all outputs 0, state=0, no power_valid pulse follows.
